// File: rtl/fft_result_reader.sv
// fft_result_reader: streams one frame of DEPTH complex FFT bins from a sample RAM
// through a 2-entry FIFO. Define FFT_READER_BITREV_EN to address the RAM in bit-reversed order.
module fft_result_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic                    ram_re,
    input  logic [2*DATA_WIDTH-1:0] ram_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_re,
    output logic [DATA_WIDTH-1:0]   out_im,
    output logic [ADDR_WIDTH-1:0]   out_idx,
    output logic                    out_last,
    output logic                    done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(DEPTH - 1);

    logic [1:0]              state;
    logic [ADDR_WIDTH-1:0]   issue_k;
    logic                    inflight;
    logic [ADDR_WIDTH-1:0]   inflight_idx;
    logic [1:0]              count;
    logic [2*DATA_WIDTH-1:0] head_data;
    logic [2*DATA_WIDTH-1:0] tail_data;
    logic [ADDR_WIDTH-1:0]   head_idx;
    logic [ADDR_WIDTH-1:0]   tail_idx;
    logic                    head_last;
    logic                    tail_last;
    logic                    push;
    logic                    pop;
    logic                    issue;
    logic                    push_last;
    logic [2:0]              occupancy;

    function automatic logic [ADDR_WIDTH-1:0] read_addr(input logic [ADDR_WIDTH-1:0] k);
`ifdef FFT_READER_BITREV_EN
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) r[i] = k[ADDR_WIDTH-1-i];
        return r;
`else
        return k;
`endif
    endfunction

    // A read may only issue if the word it returns is guaranteed a FIFO slot.
    assign push      = inflight;
    assign pop       = out_valid && out_ready;
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == READ) && (occupancy < 3'd2);
    assign ram_re    = issue;
    assign ram_addr  = issue ? read_addr(issue_k) : '0;
    assign busy      = (state != IDLE);
    assign out_valid = (count != 2'd0);
    assign out_re    = head_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign out_im    = head_data[DATA_WIDTH-1:0];
    assign out_idx   = head_idx;
    assign out_last  = head_last;
    assign push_last = (inflight_idx == LAST_K);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            issue_k <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= READ;
                        issue_k <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        issue_k <= issue_k + ADDR_WIDTH'(1);
                        if (issue_k == LAST_K) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight     <= 1'b0;
            inflight_idx <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_idx <= issue_k;
        end
    end

    // Head register drives the outputs directly, so data holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 2'd0;
            head_data <= '0;
            head_idx  <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_idx  <= '0;
            tail_last <= 1'b0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            case (count)
                2'd0: begin
                    if (push) begin
                        head_data <= ram_data;
                        head_idx  <= inflight_idx;
                        head_last <= push_last;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_data <= ram_data;
                        head_idx  <= inflight_idx;
                        head_last <= push_last;
                    end else if (push) begin
                        tail_data <= ram_data;
                        tail_idx  <= inflight_idx;
                        tail_last <= push_last;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_data <= tail_data;
                        head_idx  <= tail_idx;
                        head_last <= tail_last;
                        if (push) begin
                            tail_data <= ram_data;
                            tail_idx  <= inflight_idx;
                            tail_last <= push_last;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: scoreboard of expected beats plus table-driven frame scenarios
// and hand-written latency, reset-abort and back-to-back sequences.
module tb_fft_result_reader;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [AW-1:0] idx;
        logic          last;
    } beat_t;

    typedef struct {
        string name;
        int    ready_mode;
        int    restart_at;
        int    exp_beats;
        int    exp_dones;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic [2*DW-1:0] ram_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          done;

    logic [2*DW-1:0] mem [DEPTH];

    int    n_checks = 0;
    int    n_pass = 0;
    beat_t exp_q[$];
    int    beats_seen = 0;
    int    dones_seen = 0;
    int    issued_total = 0;
    int    accepted_total = 0;
    logic  done_due = 1'b0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    beat_t mon_e;
    logic  pop_now;
    int    ready_mode = 0;
    int    pat_i = 0;

    fft_result_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_data(ram_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    // Sample RAM with one-cycle read latency; junk on the bus when not reading.
    always @(posedge clk) begin
        if (ram_re) ram_data <= mem[ram_addr];
        else        ram_data <= 32'hDEAD_BEEF;
    end

    function automatic logic [AW-1:0] exp_addr(input int k);
        logic [AW-1:0] kk = AW'(k);
        logic [AW-1:0] r  = kk;
`ifdef FFT_READER_BITREV_EN
        for (int i = 0; i < AW; i++) r[i] = kk[AW-1-i];
`endif
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic pushFrame();
        for (int k = 0; k < DEPTH; k++) begin
            beat_t b;
            int a = int'(exp_addr(k));
            b.re   = DW'(a + 1);
            b.im   = DW'(-(a + 1));
            b.idx  = AW'(k);
            b.last = (k == DEPTH - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic waitDones(input int target, input int budget, input string name);
        int n = 0;
        while (dones_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput(name, 64'(dones_seen >= target), 64'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int b0 = beats_seen;
        int d0 = dones_seen;
        ready_mode = v.ready_mode;
        pat_i = 0;
        pushFrame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (v.restart_at >= 0) begin
            int n = 0;
            while (beats_seen - b0 <= v.restart_at && n < 500) begin
                @(posedge clk);
                n++;
            end
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        waitDones(d0 + 1, 1000, {v.name, "_done_timeout"});
        repeat (4) @(posedge clk);
        checkOutput({v.name, "_beats"}, 64'(beats_seen - b0), 64'(v.exp_beats));
        checkOutput({v.name, "_dones"}, 64'(dones_seen - d0), 64'(v.exp_dones));
        checkOutput({v.name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Downstream ready pattern: always high, 1,0,0,1 repeating, or random.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            pat_i++;
        end
    end

    // Monitor: scoreboard pop on handshake, done timing, stall stability, read addressing and occupancy.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            done_due       = 1'b0;
            prev_stall     = 1'b0;
            issued_total   = 0;
            accepted_total = 0;
        end else begin
            if (done || done_due) checkOutput("done_pulse", 64'(done), 64'(done_due));
            if (done_due) checkOutput("busy_in_done_cycle", 64'(busy), 64'd0);
            if (done) dones_seen++;
            if (prev_stall) begin
                checkOutput("stall_valid", 64'(out_valid), 64'd1);
                checkOutput("stall_hold", 64'({out_re, out_im, out_idx, out_last}), 64'(prev_beat));
            end
            pop_now = out_valid && out_ready;
            if (ram_re) begin
                checkOutput("ram_addr", 64'(ram_addr), 64'(exp_addr(issued_total % DEPTH)));
                checkOutput("occupancy_lt2", 64'((issued_total - accepted_total - int'(pop_now)) < 2), 64'd1);
                issued_total++;
            end else begin
                checkOutput("ram_addr_idle", 64'(ram_addr), 64'd0);
            end
            done_due = 1'b0;
            if (pop_now) begin
                accepted_total++;
                beats_seen++;
                checkOutput("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    checkOutput("beat", 64'({out_re, out_im, out_idx, out_last}), 64'(mon_e));
                    done_due = mon_e.last;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_re, out_im, out_idx, out_last};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        vec_t vecs[4];
        vec_t again;
        int   b0;
        int   d0;
        int   n;

        for (int a = 0; a < DEPTH; a++) mem[a] = {DW'(a + 1), DW'(-(a + 1))};
        vecs[0] = '{"ready_high",    0, -1, 16, 1};
        vecs[1] = '{"ready_1001",    1, -1, 16, 1};
        vecs[2] = '{"restart_idx5",  0,  5, 16, 1};
        vecs[3] = '{"ready_random",  2, -1, 16, 1};
        again   = '{"after_reset",   0, -1, 16, 1};

        repeat (3) @(posedge clk);
        #2 checkOutput("reset_outputs",
                       64'({busy, ram_re, ram_addr, out_valid, out_re, out_im, out_idx, out_last, done}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // First-beat latency: valid two edges after the edge that sampled start.
        ready_mode = 0;
        b0 = beats_seen;
        d0 = dones_seen;
        pushFrame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checkOutput("lat_e0_valid", 64'(out_valid), 64'd0);
        checkOutput("lat_e0_busy", 64'(busy), 64'd1);
        checkOutput("lat_e0_ram_re", 64'(ram_re), 64'd1);
        @(posedge clk); #1 checkOutput("lat_e1_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1 checkOutput("lat_e2_valid", 64'(out_valid), 64'd1);
        waitDones(d0 + 1, 1000, "lat_done_timeout");
        repeat (4) @(posedge clk);
        checkOutput("lat_beats", 64'(beats_seen - b0), 64'd16);

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        // Reset after beat idx 7 aborts the frame with no further beats or done.
        ready_mode = 0;
        b0 = beats_seen;
        pushFrame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (beats_seen - b0 < 8 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #3 rst = 1'b1;
        #1 checkOutput("abort_outputs_zero",
                       64'({busy, ram_re, ram_addr, out_valid, out_re, out_im, out_idx, out_last, done}), 64'd0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        b0 = beats_seen;
        d0 = dones_seen;
        repeat (6) @(posedge clk);
        checkOutput("abort_no_beats", 64'(beats_seen - b0), 64'd0);
        checkOutput("abort_no_done", 64'(dones_seen - d0), 64'd0);
        applyStimulus(again);

        // Start held high: second frame issues its first read in the cycle after done.
        ready_mode = 0;
        b0 = beats_seen;
        d0 = dones_seen;
        pushFrame();
        pushFrame();
        @(posedge clk); #1 start = 1'b1;
        waitDones(d0 + 1, 1000, "b2b_first_done_timeout");
        #1;
        checkOutput("b2b_restart_re", 64'(ram_re), 64'd1);
        checkOutput("b2b_restart_busy", 64'(busy), 64'd1);
        n = 0;
        while (dones_seen < d0 + 2 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        start = 1'b0;
        checkOutput("b2b_second_done_timeout", 64'(dones_seen >= d0 + 2), 64'd1);
        repeat (4) @(posedge clk);
        checkOutput("b2b_beats", 64'(beats_seen - b0), 64'd32);
        checkOutput("b2b_dones", 64'(dones_seen - d0), 64'd2);
        checkOutput("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("b2b_idle", 64'(busy), 64'd0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
